// File: rtl/gpio_arbiter.sv
// Two-requester round-robin arbiter in front of a single GPIO peripheral.
// Each granted access runs IDLE -> ACCESS (one strobe) -> RESPOND (one ack) -> IDLE.
module gpio_arbiter #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          gp_write_en,
    output logic          gp_read_en,
    output logic [DW-1:0] gp_dataw,
    input  logic [DW-1:0] gp_datar,
    output logic          busy,
    output logic [1:0]    grant
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_last1;
    logic          r_own1;
    logic          r_we;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;

    logic          r_ack0;
    logic          r_ack1;
    logic          r_write_en;
    logic          r_read_en;
    logic [DW-1:0] r_dataw;
    logic          r_busy;
    logic [1:0]    r_grant;

    logic          w_win1;
    logic          w_we_sel;
    logic [DW-1:0] w_wdata_sel;

    logic          w_ack0_nxt;
    logic          w_ack1_nxt;
    logic          w_write_en_nxt;
    logic          w_read_en_nxt;
    logic [DW-1:0] w_dataw_nxt;
    logic          w_busy_nxt;
    logic [1:0]    w_grant_nxt;

    // Requester 1 wins when alone, or on contention when requester 0 won last.
    always_comb begin
        w_win1      = req1 & (~req0 | ~r_last1);
        w_we_sel    = w_win1 ? we1 : we0;
        w_wdata_sel = w_win1 ? wdata1 : wdata0;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = S_IDLE;
        case (r_state)
            S_IDLE:    w_state_nxt = (req0 | req1) ? S_ACCESS : S_IDLE;
            S_ACCESS:  w_state_nxt = S_RESPOND;
            S_RESPOND: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Output values for the upcoming state, so every output leaves a flop.
    always_comb begin
        w_ack0_nxt     = 1'b0;
        w_ack1_nxt     = 1'b0;
        w_write_en_nxt = 1'b0;
        w_read_en_nxt  = 1'b0;
        w_dataw_nxt    = {DW{1'b0}};
        w_busy_nxt     = 1'b0;
        w_grant_nxt    = 2'b00;
        case (w_state_nxt)
            S_ACCESS: begin
                w_busy_nxt     = 1'b1;
                w_grant_nxt    = {w_win1, ~w_win1};
                w_write_en_nxt = w_we_sel;
                w_read_en_nxt  = ~w_we_sel;
                w_dataw_nxt    = w_wdata_sel;
            end
            S_RESPOND: begin
                w_busy_nxt  = 1'b1;
                w_grant_nxt = {r_own1, ~r_own1};
                w_ack0_nxt  = ~r_own1;
                w_ack1_nxt  = r_own1;
            end
            default: begin
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_write_en <= 1'b0;
            r_read_en  <= 1'b0;
            r_dataw    <= {DW{1'b0}};
            r_busy     <= 1'b0;
            r_grant    <= 2'b00;
        end else begin
            r_ack0     <= w_ack0_nxt;
            r_ack1     <= w_ack1_nxt;
            r_write_en <= w_write_en_nxt;
            r_read_en  <= w_read_en_nxt;
            r_dataw    <= w_dataw_nxt;
            r_busy     <= w_busy_nxt;
            r_grant    <= w_grant_nxt;
        end
    end

    // Latch the winner and its direction when a transaction starts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last1 <= 1'b1;
            r_own1  <= 1'b0;
            r_we    <= 1'b0;
        end else if ((r_state == S_IDLE) && (w_state_nxt == S_ACCESS)) begin
            r_last1 <= w_win1;
            r_own1  <= w_win1;
            r_we    <= w_we_sel;
        end else begin
            r_last1 <= r_last1;
            r_own1  <= r_own1;
            r_we    <= r_we;
        end
    end

    // Read data is captured only on the edge that leaves ACCESS of a read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata0 <= {DW{1'b0}};
            r_rdata1 <= {DW{1'b0}};
        end else if ((r_state == S_ACCESS) && !r_we) begin
            if (r_own1) begin
                r_rdata1 <= gp_datar;
            end else begin
                r_rdata0 <= gp_datar;
            end
        end else begin
            r_rdata0 <= r_rdata0;
            r_rdata1 <= r_rdata1;
        end
    end

    assign ack0        = r_ack0;
    assign ack1        = r_ack1;
    assign rdata0      = r_rdata0;
    assign rdata1      = r_rdata1;
    assign gp_write_en = r_write_en;
    assign gp_read_en  = r_read_en;
    assign gp_dataw    = r_dataw;
    assign busy        = r_busy;
    assign grant       = r_grant;

endmodule

// File: doc/gpio_arbiter.md
GPIO_ARBITER -- requirements
Module: gpio_arbiter

Interface
REQ-001 Parameter DW, default 16, data width of the GPIO data path and of both requester ports.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req0 / req1  input  1  access request from requester 0 (core) / requester 1 (auxiliary master).
REQ-005 we0 / we1  input  1  1 = write LEDR register, 0 = read switches; qualified by reqN.
REQ-006 wdata0 / wdata1  input  DW  write data; qualified by reqN and weN.
REQ-007 ack0 / ack1  output  1  one-cycle completion pulse to the requester.
REQ-008 rdata0 / rdata1  output  DW  registered read data for the requester.
REQ-009 gp_write_en  output  1  write strobe to the GPIO peripheral.
REQ-010 gp_read_en  output  1  read enable to the GPIO peripheral.
REQ-011 gp_dataw  output  DW  write data to the GPIO peripheral.
REQ-012 gp_datar  input  DW  combinational read data from the GPIO peripheral.
REQ-013 busy  output  1  high whenever the state is not IDLE.
REQ-014 grant  output  2  one-hot owner of the current transaction (bit0 = requester 0); 00 in IDLE.

Function
REQ-015 FSM states: IDLE, ACCESS, RESPOND; IDLE->ACCESS when req0 or req1 is sampled high; ACCESS->RESPOND unconditionally; RESPOND->IDLE unconditionally.
REQ-016 In IDLE, the winner is latched at the rising edge: single requester wins; both requesting -> the port not in last_grant wins (round-robin).
REQ-017 last_grant updates to the winner on the IDLE->ACCESS transition.
REQ-018 The winner's we and wdata are latched on the IDLE->ACCESS transition; later changes have no effect on the transaction in progress.
REQ-019 In ACCESS only: gp_write_en = latched we, gp_read_en = not latched we, gp_dataw = latched wdata; in every other state both strobes are 0 and gp_dataw = 0.
REQ-020 On a read, gp_datar is captured into the winner's rdata register at the ACCESS->RESPOND edge; the other port's rdata is unchanged.
REQ-021 On a write, neither rdata register changes.
REQ-022 In RESPOND, ack of the winner is 1 for exactly one cycle; the other ack stays 0.
REQ-023 Latency: req sampled at edge N -> strobe during cycle N..N+1 -> ack high during cycle N+1..N+2; one transaction every 3 cycles at most.
REQ-024 Requester protocol: reqN, weN and wdataN are held stable until ackN; a reqN still high in the cycle after ackN is a new request.
REQ-025 Requests arriving in ACCESS or RESPOND are ignored until the next IDLE sample; they are never lost while held.
REQ-026 grant and busy are registered and change only with the state.
REQ-027 rdataN holds its value indefinitely between reads.

Reset
REQ-028 On reset low, asynchronously: state = IDLE, last_grant = requester 1 (requester 0 wins first contention), ack0 = ack1 = 0, gp_write_en = gp_read_en = 0, gp_dataw = 0, rdata0 = rdata1 = 0, grant = 00, busy = 0.
REQ-029 Reset asserted mid-transaction aborts it: no ack is issued, and the interrupted requester re-arbitrates after reset release if its req is still high.
REQ-030 First arbitration sample is at the first rising edge with reset high.

Verification
REQ-031 Single write: req0=1, we0=1, wdata0=16'h1234 -> exactly one cycle of gp_write_en=1 with gp_dataw=16'h1234; ack0 pulses 1 cycle later; rdata0 stays 0.
REQ-032 Single read: req1=1, we1=0, gp_datar=16'h00A5 -> exactly one cycle of gp_read_en=1; rdata1=16'h00A5 while ack1 is high; rdata0 unchanged.
REQ-033 Contention: req0 and req1 held high from reset release -> grant order 01,10,01,10; acks alternate; IDLE cycles separate transactions.
REQ-034 Stability: change wdata0 from 16'h0001 to 16'hFFFF during ACCESS -> gp_dataw=16'h0001 for that transaction.
REQ-035 Reset mid-operation: assert reset during ACCESS -> strobes drop immediately; no ack; busy=0; after release with req0 held -> fresh transaction completes normally.
REQ-036 Back-to-back: req0 held through ack0 -> second transaction starts at the next IDLE sample; exactly one strobe per ack.
